// File: rtl/sdram_port_scheduler.sv
// Three-requester SDRAM command scheduler: video (fixed priority with anti-starvation), CPU/DMA round-robin.
// One transaction in flight; optional BUSY watchdog enabled by SDRAM_SCHED_WATCHDOG_EN.
module sdram_port_scheduler #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        sdram_cmd_valid,
    input  logic        sdram_cmd_ready,
    output logic        sdram_rd,
    output logic        sdram_wr,
    output logic        sdram_burst,
    output logic [23:0] sdram_addr_x16,
    output logic [15:0] sdram_wdata,
    output logic [1:0]  sdram_wmask,
    input  logic        sdram_resp_valid,
    input  logic        sdram_resp_last,
    input  logic [15:0] sdram_rdata,
    input  logic        sdram_wdone,
    input  logic        video_req,
    output logic        video_gnt,
    output logic        video_done,
    input  logic [23:0] video_addr_x16,
    output logic        video_resp_valid,
    input  logic        cpu_req,
    input  logic        dma_req,
    input  logic        cpu_wr,
    input  logic        dma_wr,
    input  logic [23:0] cpu_addr_x16,
    input  logic [23:0] dma_addr_x16,
    input  logic [15:0] cpu_wdata,
    input  logic [15:0] dma_wdata,
    input  logic [1:0]  cpu_wmask,
    input  logic [1:0]  dma_wmask,
    output logic        cpu_gnt,
    output logic        dma_gnt,
    output logic        cpu_done,
    output logic        dma_done,
    output logic        cpu_resp_valid,
    output logic        dma_resp_valid,
    output logic [15:0] resp_rdata,
    output logic        sched_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DMA  = 2'd3;

    localparam logic RR_CPU = 1'b0;
    localparam logic RR_DMA = 1'b1;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [1:0]  state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  starve_q, starve_d;
    logic        rr_last_q, rr_last_d;
    logic        cmd_rd_q, cmd_rd_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic        cmd_burst_q, cmd_burst_d;
    logic [23:0] cmd_addr_q, cmd_addr_d;
    logic [15:0] cmd_wdata_q, cmd_wdata_d;
    logic [1:0]  cmd_wmask_q, cmd_wmask_d;

    logic [1:0]  pick;
    logic        cd_req;
    logic        handshake;
    logic        complete;
    logic        finish;
    logic        wd_timeout;

    assign cd_req    = cpu_req | dma_req;
    assign handshake = (state_q == S_ISSUE) && sdram_cmd_ready;
    assign complete  = (state_q == S_BUSY) &&
                       (cmd_rd_q ? (sdram_resp_valid && sdram_resp_last) : sdram_wdone);
    assign finish    = (state_q == S_BUSY) && (complete || wd_timeout);

`ifdef SDRAM_SCHED_WATCHDOG_EN
    logic [15:0] wd_q, wd_d;

    // Counter reads 0 in the first BUSY cycle, so TIMEOUT_CYCLES-1 marks BUSY cycle TIMEOUT_CYCLES.
    assign wd_timeout = (state_q == S_BUSY) && !complete && (wd_q == 16'(TIMEOUT_CYCLES - 1));
    assign wd_d       = (state_q == S_BUSY) ? wd_q + 16'd1 : 16'd0;
    assign sched_err  = wd_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wd_q <= 16'd0;
        else       wd_q <= wd_d;
    end
`else
    assign wd_timeout = 1'b0;
    assign sched_err  = 1'b0;
`endif

    always_comb begin
        pick = OWN_NONE;
        if (cd_req && (starve_q >= STARVE_MAX || !video_req))
            pick = (cpu_req && (!dma_req || rr_last_q == RR_DMA)) ? OWN_CPU : OWN_DMA;
        else if (video_req)
            pick = OWN_VID;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        rr_last_d   = rr_last_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_burst_d = cmd_burst_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wmask_d = cmd_wmask_q;
        case (state_q)
            S_IDLE: begin
                if (pick != OWN_NONE) begin
                    state_d = S_ISSUE;
                    owner_d = pick;
                    case (pick)
                        OWN_VID: begin
                            cmd_rd_d    = 1'b1;
                            cmd_wr_d    = 1'b0;
                            cmd_burst_d = 1'b1;
                            cmd_addr_d  = video_addr_x16;
                            cmd_wdata_d = 16'd0;
                            cmd_wmask_d = 2'b00;
                        end
                        OWN_CPU: begin
                            cmd_rd_d    = !cpu_wr;
                            cmd_wr_d    = cpu_wr;
                            cmd_burst_d = 1'b0;
                            cmd_addr_d  = cpu_addr_x16;
                            cmd_wdata_d = cpu_wdata;
                            cmd_wmask_d = cpu_wmask;
                        end
                        default: begin
                            cmd_rd_d    = !dma_wr;
                            cmd_wr_d    = dma_wr;
                            cmd_burst_d = 1'b0;
                            cmd_addr_d  = dma_addr_x16;
                            cmd_wdata_d = dma_wdata;
                            cmd_wmask_d = dma_wmask;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (sdram_cmd_ready) begin
                    state_d = S_BUSY;
                    if (owner_q == OWN_VID) begin
                        if (cd_req && starve_q < STARVE_MAX)
                            starve_d = starve_q + 8'd1;
                    end else begin
                        starve_d  = 8'd0;
                        rr_last_d = (owner_q == OWN_CPU) ? RR_CPU : RR_DMA;
                    end
                end
            end
            S_BUSY: begin
                if (finish) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= 8'd0;
            rr_last_q   <= RR_DMA;
            cmd_rd_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_burst_q <= 1'b0;
            cmd_addr_q  <= 24'd0;
            cmd_wdata_q <= 16'd0;
            cmd_wmask_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            rr_last_q   <= rr_last_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_burst_q <= cmd_burst_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wmask_q <= cmd_wmask_d;
        end
    end

    assign sdram_cmd_valid = (state_q == S_ISSUE);
    assign sdram_rd        = cmd_rd_q;
    assign sdram_wr        = cmd_wr_q;
    assign sdram_burst     = cmd_burst_q;
    assign sdram_addr_x16  = cmd_addr_q;
    assign sdram_wdata     = cmd_wdata_q;
    assign sdram_wmask     = cmd_wmask_q;

    assign video_gnt = handshake && (owner_q == OWN_VID);
    assign cpu_gnt   = handshake && (owner_q == OWN_CPU);
    assign dma_gnt   = handshake && (owner_q == OWN_DMA);

    assign video_done = finish && (owner_q == OWN_VID);
    assign cpu_done   = finish && (owner_q == OWN_CPU);
    assign dma_done   = finish && (owner_q == OWN_DMA);

    assign video_resp_valid = (state_q == S_BUSY) && (owner_q == OWN_VID) && sdram_resp_valid;
    assign cpu_resp_valid   = (state_q == S_BUSY) && (owner_q == OWN_CPU) && sdram_resp_valid;
    assign dma_resp_valid   = (state_q == S_BUSY) && (owner_q == OWN_DMA) && sdram_resp_valid;

    assign resp_rdata = sdram_rdata;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler: burst read, CPU write, round-robin, starvation, stall/reset, watchdog.
module tb_sdram_port_scheduler;

`ifdef SDRAM_SCHED_WATCHDOG_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sdram_cmd_valid, sdram_cmd_ready;
    logic        sdram_rd, sdram_wr, sdram_burst;
    logic [23:0] sdram_addr_x16;
    logic [15:0] sdram_wdata;
    logic [1:0]  sdram_wmask;
    logic        sdram_resp_valid, sdram_resp_last, sdram_wdone;
    logic [15:0] sdram_rdata;
    logic        video_req, video_gnt, video_done, video_resp_valid;
    logic [23:0] video_addr_x16;
    logic        cpu_req, dma_req, cpu_wr, dma_wr;
    logic [23:0] cpu_addr_x16, dma_addr_x16;
    logic [15:0] cpu_wdata, dma_wdata;
    logic [1:0]  cpu_wmask, dma_wmask;
    logic        cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_resp_valid, dma_resp_valid;
    logic [15:0] resp_rdata;
    logic        sched_err;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_scheduler #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .sdram_cmd_valid(sdram_cmd_valid), .sdram_cmd_ready(sdram_cmd_ready),
        .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_burst(sdram_burst),
        .sdram_addr_x16(sdram_addr_x16), .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask),
        .sdram_resp_valid(sdram_resp_valid), .sdram_resp_last(sdram_resp_last),
        .sdram_rdata(sdram_rdata), .sdram_wdone(sdram_wdone),
        .video_req(video_req), .video_gnt(video_gnt), .video_done(video_done),
        .video_addr_x16(video_addr_x16), .video_resp_valid(video_resp_valid),
        .cpu_req(cpu_req), .dma_req(dma_req), .cpu_wr(cpu_wr), .dma_wr(dma_wr),
        .cpu_addr_x16(cpu_addr_x16), .dma_addr_x16(dma_addr_x16),
        .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
        .cpu_wmask(cpu_wmask), .dma_wmask(dma_wmask),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_done(cpu_done), .dma_done(dma_done),
        .cpu_resp_valid(cpu_resp_valid), .dma_resp_valid(dma_resp_valid),
        .resp_rdata(resp_rdata), .sched_err(sched_err)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        sdram_cmd_ready = 1'b0; sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0;
        sdram_rdata = 16'd0; sdram_wdone = 1'b0;
        video_req = 1'b0; video_addr_x16 = 24'd0;
        cpu_req = 1'b0; dma_req = 1'b0; cpu_wr = 1'b0; dma_wr = 1'b0;
        cpu_addr_x16 = 24'd0; dma_addr_x16 = 24'd0;
        cpu_wdata = 16'd0; dma_wdata = 16'd0; cpu_wmask = 2'b00; dma_wmask = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        while (!sdram_cmd_valid && n < 20) begin
            step();
            n++;
        end
        check_eq(tag, {31'd0, sdram_cmd_valid}, 32'd1);
    endtask

    // Single-beat read completion for whoever is in BUSY
    task automatic finish_read();
        sdram_resp_valid = 1'b1;
        sdram_resp_last  = 1'b1;
        #1;
        step();
        sdram_resp_valid = 1'b0;
        sdram_resp_last  = 1'b0;
    endtask

    logic [9:0] starve_pat;
    int         beats;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        check_eq("rst_outs",
                 {20'd0, sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst, video_gnt, video_done,
                  video_resp_valid, cpu_gnt, dma_gnt, cpu_done, dma_done, sched_err}, 32'd0);
        check_eq("rst_addr", {8'd0, sdram_addr_x16}, 32'd0);
        check_eq("rst_wdata", {14'd0, sdram_wmask, sdram_wdata}, 32'd0);
        rst_i = 1'b0;
        step();
        check_eq("idle_noreq", {31'd0, sdram_cmd_valid}, 32'd0);

        // Video burst read, 8 beats
        video_req = 1'b1; video_addr_x16 = 24'h000100; sdram_cmd_ready = 1'b1;
        step();
        check_eq("v_cmd", {28'd0, sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst}, 32'b1101);
        check_eq("v_addr", {8'd0, sdram_addr_x16}, 32'h100);
        check_eq("v_wmask", {30'd0, sdram_wmask}, 32'd0);
        check_eq("v_gnt", {30'd0, video_gnt, cpu_gnt}, 32'b10);
        step();
        check_eq("v_busy", {30'd0, sdram_cmd_valid, video_gnt}, 32'd0);
        beats = 0;
        for (int i = 1; i <= 8; i++) begin
            sdram_resp_valid = 1'b1;
            sdram_resp_last  = (i == 8);
            sdram_rdata      = 16'(i * 16'h1111);
            #1;
            if (video_resp_valid) beats++;
            check_eq("v_done", {31'd0, video_done}, (i == 8) ? 32'd1 : 32'd0);
            if (i == 3) check_eq("v_rdata", {16'd0, resp_rdata}, 32'h3333);
            step();
        end
        sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0;
        check_eq("v_beats", beats, 8);
        check_eq("v_gap1", {31'd0, sdram_cmd_valid}, 32'd0);
        step();
        check_eq("v_gap2", {30'd0, sdram_cmd_valid, video_gnt}, 32'b11);
        video_req = 1'b0;
        step();
        finish_read();

        // CPU write
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr_x16 = 24'h123456;
        cpu_wdata = 16'hBEEF; cpu_wmask = 2'b10;
        step();
        check_eq("w_cmd", {28'd0, sdram_cmd_valid, sdram_rd, sdram_wr, sdram_burst}, 32'b1010);
        check_eq("w_addr", {8'd0, sdram_addr_x16}, 32'h123456);
        check_eq("w_data", {14'd0, sdram_wmask, sdram_wdata}, {14'd0, 2'b10, 16'hBEEF});
        check_eq("w_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 1'b0;
        step();
        step();
        check_eq("w_nodone", {31'd0, cpu_done}, 32'd0);
        sdram_wdone = 1'b1;
        #1;
        check_eq("w_done", {31'd0, cpu_done}, 32'd1);
        step();
        sdram_wdone = 1'b0;

        // CPU/DMA round-robin from reset
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; sdram_cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cmd("rr_cmd");
            check_eq("rr_gnt", {30'd0, cpu_gnt, dma_gnt}, (k % 2 == 0) ? 32'b10 : 32'b01);
            step();
            sdram_resp_valid = 1'b1; sdram_resp_last = 1'b1;
            #1;
            check_eq("rr_done", {30'd0, cpu_done, dma_done}, (k % 2 == 0) ? 32'b10 : 32'b01);
            step();
            sdram_resp_valid = 1'b0; sdram_resp_last = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;

        // Starvation: video always requesting, CPU pending
        do_reset();
        starve_pat = 10'b1000010000;
        video_req = 1'b1; cpu_req = 1'b1; sdram_cmd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_cmd("stv_cmd");
            check_eq("stv_gnt", {30'd0, video_gnt, cpu_gnt}, starve_pat[k] ? 32'b01 : 32'b10);
            step();
            finish_read();
        end
        video_req = 1'b0; cpu_req = 1'b0;

        // Stalled ISSUE, late field changes ignored, reset during BUSY
        do_reset();
        cpu_req = 1'b1; cpu_addr_x16 = 24'hABCDEF;
        step();
        cpu_addr_x16 = 24'h111111;
        for (int i = 0; i < 5; i++) begin
            check_eq("st_hold", {30'd0, sdram_cmd_valid, cpu_gnt}, 32'b10);
            step();
        end
        check_eq("st_addr", {8'd0, sdram_addr_x16}, 32'hABCDEF);
        sdram_cmd_ready = 1'b1;
        #1;
        check_eq("st_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 1'b0;
        step();
        sdram_resp_valid = 1'b1;
        #1;
        check_eq("st_rv", {29'd0, cpu_resp_valid, dma_resp_valid, video_resp_valid}, 32'b100);
        rst_i = 1'b1;
        #1;
        check_eq("st_rst", {28'd0, sdram_cmd_valid, cpu_resp_valid, cpu_done, sdram_rd}, 32'd0);
        check_eq("st_rst_addr", {8'd0, sdram_addr_x16}, 32'd0);
        sdram_resp_valid = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        check_eq("st_idle", {31'd0, sdram_cmd_valid}, 32'd0);
        cpu_req = 1'b1;
        step();
        check_eq("st_again", {8'd0, sdram_addr_x16}, 32'h111111);
        check_eq("st_again_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 1'b0;
        step();
        finish_read();

`ifdef SDRAM_SCHED_WATCHDOG_EN
        // Watchdog: read never completes
        do_reset();
        cpu_req = 1'b1; sdram_cmd_ready = 1'b1;
        step();
        check_eq("wd_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 1'b0;
        step();
        for (int b = 1; b <= 16; b++) begin
            check_eq("wd_err", {30'd0, sched_err, cpu_done}, (b == 16) ? 32'b11 : 32'b00);
            if (b < 16) step();
        end
        step();
        cpu_req = 1'b1;
        step();
        check_eq("wd_next", {30'd0, sdram_cmd_valid, cpu_gnt}, 32'b11);
        cpu_req = 1'b0;
        step();
        finish_read();
        check_eq("wd_quiet", {31'd0, sched_err}, 32'd0);
`else
        check_eq("no_wd_err", {31'd0, sched_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
